fir_serial_mac: RTL and testbench
=================================

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 SHALL have parameter NTAPS, default 61, number of filter taps (range 2..64).
REQ-002 SHALL have parameter DATA_W, default 16, sample and output width (signed two's complement).
REQ-003 SHALL have parameter COEF_W, default 16, coefficient width (signed, Q1.15).
REQ-004 SHALL have parameter ACC_W, default 40, accumulator width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port filter_in  input  DATA_W  new input sample.
REQ-008 SHALL have port in_valid  input  1  filter_in holds a valid sample.
REQ-009 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-010 SHALL have port coef_addr  output  6  coefficient ROM address.
REQ-011 SHALL have port coef_data  input  COEF_W  ROM q; valid exactly one cycle after coef_addr is presented.
REQ-012 SHALL have port filter_out  output  DATA_W  filtered sample.
REQ-013 SHALL have port out_valid  output  1  single-cycle pulse; filter_out is new.

Function
REQ-014 SHALL accept a sample on any rising edge where in_valid and in_ready are both high, writing it as x[n] into a NTAPS-deep circular buffer.
REQ-015 SHALL assert in_ready only in state IDLE; in_valid outside IDLE is ignored, not queued.
REQ-016 SHALL use FSM states IDLE -> MAC (on accept) -> DRAIN (after NTAPS address cycles) -> OUT (1 cycle) -> IDLE.
REQ-017 SHALL, in MAC, present coef_addr = k and read x[n-k] for k = 0..NTAPS-1, one tap per cycle, k ascending.
REQ-018 SHALL form a signed full-precision COEF_W x DATA_W product and accumulate it sign-extended to ACC_W; accumulator cleared on accept.
REQ-019 SHALL compute the result as (acc + 2^14) arithmetic-shifted right by 15, saturated to [-32768, 32767].
REQ-020 SHALL update filter_out and pulse out_valid high for one cycle exactly NTAPS+3 rising edges after the accepting edge; filter_out holds its value until the next result.
REQ-021 SHALL wrap the buffer write pointer from NTAPS-1 to 0, with read index (wr_ptr - k) computed modulo NTAPS.
REQ-022 SHALL treat buffer entries not yet written since reset as zero.
REQ-023 SHALL return to IDLE on the edge after OUT, so the earliest next accept is NTAPS+4 edges after the previous one.
REQ-024 SHALL drive coef_addr to 0 outside MAC.

Reset
REQ-025 SHALL, while reset is high, force state IDLE, in_ready 1, out_valid 0, filter_out 0, coef_addr 0, accumulator 0, write pointer 0, and all buffer entries 0.
REQ-026 SHALL abort any computation in progress on reset without emitting out_valid.

Structure
REQ-027 SHALL take the state encoding, ACC_W, the rounding constant and the saturation limits from a shared package fir_pkg.
REQ-028 SHALL implement the circular delay line as one sub-module, fir_sample_buffer, with write port and one combinational read port.

Verification
REQ-029 Impulse: ROM model c[k]=k+1, input 32767 then 60 zeros -> outputs 1,2,3,...,61 in order.
REQ-030 Saturation: all c[k]=0x7FFF, 61 samples of 0x7FFF -> final output 0x7FFF; repeat with 0x8000 -> 0x8000.
REQ-031 Handshake: in_valid held high continuously -> accepts exactly every 65 cycles (NTAPS=61), in_ready low 64 of 65 cycles, out_valid 64 cycles after each accept.
REQ-032 Reset mid-MAC: assert reset 20 cycles after an accept -> no out_valid; in_ready=1 on the first edge after release; the next impulse reproduces the REQ-029 sequence from 1.
REQ-033 Wrap-around: 200 random samples with random coefficients -> every output bit-exact against a reference model, including outputs after the pointer wraps.

Source files
------------

// File: rtl/fir_serial_mac_pkg.sv
// Shared definitions for the serial-MAC FIR filter: FSM encoding, accumulator
// width, rounding constant and output saturation limits.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } fir_state_e;

   localparam int ADDR_W       = 6;
   localparam int FIR_ACC_W    = 40;
   localparam int FRAC_BITS    = 15;
   localparam int RND_CONST    = 1 << 14;
   localparam int SAT_MAX      = 32767;
   localparam int SAT_MIN      = -32768;
   // Two pipeline stages (tap read, product) trail the last coefficient address.
   localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample stream, coefficient ROM port and result stream of fir_serial_mac.
interface fir_serial_mac_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16
);
   import fir_pkg::*;

   // A sample transfers on a rising edge where in_valid and in_ready are both
   // high; in_valid while in_ready is low is dropped, never queued. out_valid is
   // a one-cycle pulse marking a new filter_out, with no backpressure.
   logic signed [DATA_W-1:0] filter_in;
   logic                     in_valid;
   logic                     in_ready;
   logic [ADDR_W-1:0]        coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic signed [DATA_W-1:0] filter_out;
   logic                     out_valid;
   fir_state_e               dbg_state;

   modport slave (
      input  filter_in, in_valid, coef_data,
      output in_ready, coef_addr, filter_out, out_valid, dbg_state
   );

   modport master (
      output filter_in, in_valid, coef_data,
      input  in_ready, coef_addr, filter_out, out_valid, dbg_state
   );

endinterface

// File: rtl/fir_sample_buffer.sv
// Circular delay line: one synchronous write port, one combinational read port.
// Every entry clears on reset so unwritten history reads as zero.
module fir_sample_buffer #(
   parameter int NTAPS  = 61,
   parameter int DATA_W = 16,
   parameter int AW     = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]            rd_addr,
   output logic signed [DATA_W-1:0] rd_data
);

   logic signed [DATA_W-1:0] mem_q [NTAPS];
   logic signed [DATA_W-1:0] mem_d [NTAPS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_serial_mac.sv
// Single-multiplier FIR: one tap per cycle against an external coefficient ROM
// with one cycle of read latency, rounded and saturated to DATA_W.
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int NTAPS  = 61,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = FIR_ACC_W
) (
   input  logic          clk,
   input  logic          reset,
   fir_serial_mac_if.slave bus
);

   localparam int PROD_W = COEF_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NTAPS - 1);
   localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(DRAIN_CYCLES - 1);

   fir_state_e               state_q, state_d;
   logic [ADDR_W-1:0]        k_q, k_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic signed [DATA_W-1:0] x_q, x_d;
   logic                     tap_v_q, tap_v_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     prod_v_q, prod_v_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] filter_out_q, filter_out_d;
   logic                     out_valid_q, out_valid_d;

   logic                     accept;
   logic [ADDR_W-1:0]        rd_idx;
   logic signed [DATA_W-1:0] rd_data;
   logic signed [ACC_W-1:0]  rnd_sum, shifted;
   logic signed [DATA_W-1:0] sat_val;

   fir_sample_buffer #(
      .NTAPS (NTAPS),
      .DATA_W(DATA_W),
      .AW    (ADDR_W)
   ) u_buf (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (accept),
      .wr_addr(wr_ptr_q),
      .wr_data(bus.filter_in),
      .rd_addr(rd_idx),
      .rd_data(rd_data)
   );

   // wr_ptr_q points at the newest sample until OUT, so x[n-k] sits at wr_ptr-k.
   always_comb begin
      if (wr_ptr_q >= k_q) rd_idx = wr_ptr_q - k_q;
      else                 rd_idx = wr_ptr_q + ADDR_W'(NTAPS) - k_q;
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      wr_ptr_d = wr_ptr_q;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ST_MAC;
               k_d     = '0;
            end
         end
         ST_MAC: begin
            if (k_q == LAST_TAP) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (k_q == LAST_DRAIN) begin
               state_d = ST_OUT;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_OUT: begin
            state_d  = ST_IDLE;
            wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pipeline: tap read aligns with the ROM latency, then multiply, then accumulate.
   always_comb begin
      x_d      = rd_data;
      tap_v_d  = (state_q == ST_MAC);
      prod_d   = PROD_W'(bus.coef_data) * PROD_W'(x_q);
      prod_v_d = tap_v_q;
      if (accept)        acc_d = '0;
      else if (prod_v_q) acc_d = acc_q + ACC_W'(prod_q);
      else               acc_d = acc_q;
   end

   always_comb begin
      rnd_sum = acc_q + ACC_W'(RND_CONST);
      shifted = rnd_sum >>> FRAC_BITS;
      if (shifted > ACC_W'(SAT_MAX))      sat_val = DATA_W'(SAT_MAX);
      else if (shifted < ACC_W'(SAT_MIN)) sat_val = DATA_W'(SAT_MIN);
      else                                sat_val = shifted[DATA_W-1:0];
      filter_out_d = filter_out_q;
      out_valid_d  = 1'b0;
      if (state_q == ST_OUT) begin
         filter_out_d = sat_val;
         out_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         wr_ptr_q     <= '0;
         x_q          <= '0;
         tap_v_q      <= 1'b0;
         prod_q       <= '0;
         prod_v_q     <= 1'b0;
         acc_q        <= '0;
         filter_out_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         wr_ptr_q     <= wr_ptr_d;
         x_q          <= x_d;
         tap_v_q      <= tap_v_d;
         prod_q       <= prod_d;
         prod_v_q     <= prod_v_d;
         acc_q        <= acc_d;
         filter_out_q <= filter_out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.coef_addr  = (state_q == ST_MAC) ? k_q : '0;
   assign bus.filter_out = filter_out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed and randomised checks of fir_serial_mac against a sample-history
// reference model and hand-computed results.
module tb_fir_serial_mac;
   import fir_pkg::*;

   localparam int NTAPS  = 61;
   localparam int DATA_W = 16;
   localparam int COEF_W = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fir_serial_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

   fir_serial_mac #(
      .NTAPS (NTAPS),
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (40)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic signed [COEF_W-1:0] coef_mem [64];
   logic signed [DATA_W-1:0] hist[$];
   logic [DATA_W-1:0]        exp_q[$];
   logic [DATA_W-1:0]        got_q[$];
   logic [DATA_W-1:0]        last_out;
   int acc_cyc_q[$];
   int acc_low_q[$];
   int out_cyc_q[$];
   int cyc       = 0;
   int low_total = 0;
   int out_total = 0;
   int n_checks  = 0;
   int n_fail    = 0;

   // Coefficient ROM with one cycle of read latency.
   always @(posedge clk) bus.coef_data <= coef_mem[bus.coef_addr];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_out();
      longint acc;
      longint r;
      int     n;
      acc = 0;
      n   = hist.size() - 1;
      for (int k = 0; k < NTAPS; k++) begin
         if (n - k >= 0) acc += longint'(coef_mem[k]) * longint'(hist[n - k]);
      end
      r = (acc + 16384) >>> 15;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return DATA_W'(r);
   endfunction

   // Accept monitor: logs each handshake and queues the model's result.
   always @(posedge clk) begin
      cyc++;
      if (!reset && bus.in_valid && bus.in_ready) begin
         hist.push_back(bus.filter_in);
         exp_q.push_back(model_out());
         acc_cyc_q.push_back(cyc);
         acc_low_q.push_back(low_total);
      end
   end

   // Output scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (!bus.in_ready) low_total++;
         if (bus.out_valid) begin
            out_total++;
            last_out = bus.filter_out;
            got_q.push_back(bus.filter_out);
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) check_eq("unexpected_out_valid", 32'd1, 32'd0);
            else check_eq("filter_out", {16'b0, bus.filter_out}, {16'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.filter_in = '0;
      repeat (2) @(negedge clk);
      hist.delete();
      exp_q.delete();
      got_q.delete();
      acc_cyc_q.delete();
      acc_low_q.delete();
      out_cyc_q.delete();
      reset = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] x);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_eq("ready_wait", 32'(guard < 200), 32'd1);
      bus.filter_in = x;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      check_eq(tag, exp_q.size(), 32'd0);
   endtask

   task automatic set_ramp_coefs();
      for (int k = 0; k < 64; k++) coef_mem[k] = COEF_W'(k + 1);
   endtask

   task automatic run_impulse(input string tag);
      send(16'h7FFF);
      repeat (60) send(16'h0000);
      wait_drain({tag, "_drain"});
      check_eq({tag, "_count"}, got_q.size(), 32'd61);
      for (int i = 0; i < 61 && i < got_q.size(); i++) check_eq(tag, {16'b0, got_q[i]}, 32'(i + 1));
   endtask

   initial begin
      int guard;
      int v;
      int snap;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.filter_in = '0;
      set_ramp_coefs();
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready",   bus.in_ready,   32'd1);
      check_eq("rst_out_valid",  bus.out_valid,  32'd0);
      check_eq("rst_filter_out", {16'b0, bus.filter_out}, 32'd0);
      check_eq("rst_coef_addr",  bus.coef_addr,  32'd0);
      check_eq("rst_state",      bus.dbg_state,  ST_IDLE);
      reset = 1'b0;

      run_impulse("impulse");

      // Saturation at both rails.
      for (int k = 0; k < 64; k++) coef_mem[k] = 16'sh7FFF;
      do_reset();
      repeat (61) send(16'h7FFF);
      wait_drain("sat_pos_drain");
      check_eq("sat_pos_final", last_out, 32'h7FFF);
      repeat (61) send(16'h8000);
      wait_drain("sat_neg_drain");
      check_eq("sat_neg_final", last_out, 32'h8000);
      check_eq("sat_count", got_q.size(), 32'd122);

      // Continuous in_valid: accept cadence, ready-low cycles and latency.
      set_ramp_coefs();
      do_reset();
      bus.filter_in = 16'd1000;
      bus.in_valid  = 1'b1;
      guard = 0;
      while (acc_cyc_q.size() < 4 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      wait_drain("hs_drain");
      check_eq("hs_accepts", acc_cyc_q.size(), 32'd4);
      for (int i = 1; i < acc_cyc_q.size(); i++) begin
         check_eq("hs_interval",  acc_cyc_q[i] - acc_cyc_q[i-1], 32'd65);
         check_eq("hs_ready_low", acc_low_q[i] - acc_low_q[i-1], 32'd64);
      end
      for (int i = 0; i < acc_cyc_q.size() && i < out_cyc_q.size(); i++)
         check_eq("hs_latency", out_cyc_q[i] - acc_cyc_q[i], 32'd64);

      // Reset in the middle of a MAC pass.
      do_reset();
      send(16'h7FFF);
      repeat (19) @(negedge clk);
      snap = out_total;
      do_reset();
      @(posedge clk);
      #1;
      check_eq("ready_after_reset", bus.in_ready, 32'd1);
      repeat (80) @(negedge clk);
      check_eq("no_out_after_abort", out_total - snap, 32'd0);
      run_impulse("impulse_after_reset");

      // Random coefficients and samples, long enough to wrap the pointer.
      for (int k = 0; k < 64; k++) begin
         v = int'($urandom_range(0, 2047)) - 1024;
         coef_mem[k] = v[15:0];
      end
      do_reset();
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(16'($urandom_range(0, 65535)));
      end
      wait_drain("rand_drain");
      check_eq("rand_count", got_q.size(), 32'd200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
